// File: rtl/aidc_lite_comp_zrle_param.sv
// ---------------------------------------------------------------------------
// aidc_lite_comp_zrle_param
//
// Parametrised zero-run / zero-symbol compressor. Each input beat is split
// into N = DATA_W/SYM_W symbols. The beat is coded as an N-bit zero bitmap
// (MSB = highest symbol, 1 = symbol is zero), followed by the non-zero
// symbols, highest index first. The variable-length codes are packed MSB-first
// into OUT_W-bit words that are numbered from 0 within each block. At block
// end the total code size is reported, together with a fail flag that is set
// when the size exceeds FAIL_BITS.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   valid_i/ready_o  input beat handshake; sop_i/eop_i mark block bounds
//   data_i           input beat (DATA_W)
//   valid_o/ready_i  output word handshake
//   addr_o           word index within the block
//   data_o           packed code word (OUT_W), MSB-first
//   done_o           one-cycle block-end pulse, qualifies fail_o/blk_bits_o
//   fail_o           blk_bits_o > FAIL_BITS
//   blk_bits_o       total code bits of the block
//   abort_o          one-cycle pulse when a sop abandons a running block
// ---------------------------------------------------------------------------
module aidc_lite_comp_zrle_param #(
    parameter int DATA_W    = 64,
    parameter int SYM_W     = 16,
    parameter int OUT_W     = 64,
    parameter int BLK_BEATS = 16,
    parameter int FAIL_BITS = 512,
    localparam int N         = DATA_W / SYM_W,
    localparam int CODE_MAX  = N + DATA_W,
    localparam int BITS_W    = $clog2(BLK_BEATS * CODE_MAX + 1),
    localparam int WORDS_MAX = (BLK_BEATS * CODE_MAX + OUT_W - 1) / OUT_W,
    localparam int ADDR_W    = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [OUT_W-1:0]  data_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [BITS_W-1:0] blk_bits_o,
    output logic              abort_o
);

    // The buffer only accepts a beat while fill < OUT_W, so it never needs
    // more than OUT_W-1 leftover bits plus one maximum-size code.
    localparam int BUF_W  = OUT_W - 1 + CODE_MAX;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int SIZE_W = $clog2(CODE_MAX + 1);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    shiftBuf_q, shiftBuf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   wordCnt_q, wordCnt_d;
    logic [BITS_W-1:0]   blkBits_q, blkBits_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                abort_q, abort_d;

    logic [N-1:0]        bitmap;
    logic [CODE_MAX-1:0] codeAcc;
    logic [CODE_MAX-1:0] codeAligned;
    logic [SIZE_W-1:0]   codeSize;
    logic [BUF_W-1:0]    codeTop;
    logic                accept;
    logic                canLoad;

    // Build the code right-aligned by shifting in each non-zero symbol
    // after the bitmap, then left-align it so it can be OR-ed into the buffer.
    always_comb begin
        bitmap   = '0;
        codeSize = SIZE_W'(N);
        for (int k = 0; k < N; k++) begin
            bitmap[k] = (data_i[k*SYM_W +: SYM_W] == '0);
        end
        codeAcc = CODE_MAX'(bitmap);
        for (int k = N - 1; k >= 0; k--) begin
            if (!bitmap[k]) begin
                codeAcc  = (codeAcc << SYM_W) | CODE_MAX'(data_i[k*SYM_W +: SYM_W]);
                codeSize = codeSize + SIZE_W'(SYM_W);
            end
        end
        codeAligned = codeAcc << (SIZE_W'(CODE_MAX) - codeSize);
        codeTop     = {codeAligned, {(BUF_W - CODE_MAX){1'b0}}};
    end

    assign ready_o = ((state_q == IDLE) || (state_q == RUN)) && (fill_q < OUT_W_F);
    assign accept  = valid_i && ready_o;
    // The output register may be reloaded when it is empty or drained now.
    assign canLoad = !valid_q || ready_i;

    // Next-state logic: output register loading, beat packing and block FSM.
    // Loading and accepting are mutually exclusive because accepting needs
    // fill < OUT_W while a full-word load needs fill >= OUT_W (a partial
    // load only happens in FLUSH, where no beats are accepted).
    always_comb begin
        state_d    = state_q;
        shiftBuf_d = shiftBuf_q;
        fill_d     = fill_q;
        wordCnt_d  = wordCnt_q;
        blkBits_d  = blkBits_q;
        valid_d    = valid_q;
        data_d     = data_q;
        addr_d     = addr_q;
        abort_d    = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (canLoad && ((fill_q >= OUT_W_F) || ((state_q == FLUSH) && (fill_q != '0)))) begin
            valid_d    = 1'b1;
            data_d     = shiftBuf_q[BUF_W-1 -: OUT_W];
            addr_d     = wordCnt_q;
            wordCnt_d  = wordCnt_q + ADDR_W'(1);
            shiftBuf_d = shiftBuf_q << OUT_W;
            fill_d     = (fill_q >= OUT_W_F) ? (fill_q - OUT_W_F) : '0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && sop_i) begin
                    shiftBuf_d = codeTop;
                    fill_d     = FILL_W'(codeSize);
                    wordCnt_d  = '0;
                    blkBits_d  = BITS_W'(codeSize);
                    state_d    = eop_i ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (sop_i) begin
                        // A new block abandons the current one; an already
                        // loaded output word is left to complete.
                        abort_d    = 1'b1;
                        shiftBuf_d = codeTop;
                        fill_d     = FILL_W'(codeSize);
                        wordCnt_d  = '0;
                        blkBits_d  = BITS_W'(codeSize);
                    end else begin
                        shiftBuf_d = shiftBuf_q | (codeTop >> fill_q);
                        fill_d     = fill_q + FILL_W'(codeSize);
                        blkBits_d  = blkBits_q + BITS_W'(codeSize);
                    end
                    if (eop_i) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if ((fill_q == '0) && canLoad) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftBuf_q <= '0;
            fill_q     <= '0;
            wordCnt_q  <= '0;
            blkBits_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftBuf_q <= shiftBuf_d;
            fill_q     <= fill_d;
            wordCnt_q  <= wordCnt_d;
            blkBits_q  <= blkBits_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            abort_q    <= abort_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign addr_o     = addr_q;
    assign abort_o    = abort_q;
    assign done_o     = (state_q == DONE);
    assign blk_bits_o = done_o ? blkBits_q : '0;
    assign fail_o     = done_o && (32'(blkBits_q) > 32'(FAIL_BITS));

endmodule

// File: tb/tb_aidc_lite_comp_zrle_param.sv
// ---------------------------------------------------------------------------
// tb_aidc_lite_comp_zrle_param
//
// Directed bench for aidc_lite_comp_zrle_param with default parameters
// (64-bit beats, 16-bit symbols, 64-bit words). Output words are collected
// by a monitor; expected words, sizes and flags are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_aidc_lite_comp_zrle_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        sop_i;
    logic        eop_i;
    logic [63:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  addr_o;
    logic [63:0] data_o;
    logic        done_o;
    logic        fail_o;
    logic [10:0] blk_bits_o;
    logic        abort_o;

    int checks = 0;
    int errors = 0;

    logic [4:0]  gotAddr[$];
    logic [63:0] gotData[$];
    int          doneCnt  = 0;
    int          abortCnt = 0;

    aidc_lite_comp_zrle_param dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sop_i      (sop_i),
        .eop_i      (eop_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .done_o     (done_o),
        .fail_o     (fail_o),
        .blk_bits_o (blk_bits_o),
        .abort_o    (abort_o)
    );

    always #5 clk = ~clk;

    // Records every word that will handshake on the coming rising edge, and
    // counts block-end and abort pulses.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            gotAddr.push_back(addr_o);
            gotData.push_back(data_o);
        end
        if (done_o) doneCnt++;
        if (abort_o) abortCnt++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and holds it until accepted; returns the number of
    // falling edges spent waiting for ready_o.
    task automatic applyStimulus(input logic s, input logic e, input logic [63:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        valid_i = 1'b1;
        sop_i   = s;
        eop_i   = e;
        data_i  = d;
        while (!ready_o && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("beatAccepted", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input logic [10:0] expBits, input logic expFail);
        int n = 0;
        @(negedge clk);
        while (!done_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_doneSeen"}, done_o, 1);
        checkOutput({tag, "_blkBits"}, blk_bits_o, expBits);
        checkOutput({tag, "_fail"}, fail_o, expFail);
        @(negedge clk);
    endtask

    // Word j of a block of 16 beats of 0x1111..: the stream is 17-nibble
    // codes "0111..1", so word j has its zero nibble at nibble j (from MSB),
    // and the 17th word has none.
    function automatic logic [63:0] onesWord(input int j);
        logic [63:0] w;
        w = 64'h1111_1111_1111_1111;
        if (j < 16) w[63-4*j -: 4] = 4'h0;
        return w;
    endfunction

    initial begin
        int w;
        int base;
        int doneBase;
        int abortBase;
        logic [63:0] heldData;
        logic [4:0]  heldAddr;

        rst     = 1'b1;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_abort", abort_o, 0);
        checkOutput("rst_fail", fail_o, 0);
        checkOutput("rst_addr", addr_o, 0);
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_bits", blk_bits_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 16 all-zero beats -> one all-ones word
        $display("[TB] all-zero block");
        base = gotData.size();
        for (int i = 0; i < 16; i++) applyStimulus(i == 0, i == 15, 64'h0, w);
        waitDone("allZero", 11'd64, 1'b0);
        checkOutput("allZero_words", gotData.size() - base, 1);
        checkOutput("allZero_addr", gotAddr[base], 0);
        checkOutput("allZero_data", gotData[base], 64'hFFFF_FFFF_FFFF_FFFF);

        // Single beat with one non-zero symbol
        $display("[TB] single beat block");
        base = gotData.size();
        applyStimulus(1'b1, 1'b1, 64'h0000_0000_0000_1234, w);
        waitDone("single", 11'd20, 1'b0);
        checkOutput("single_words", gotData.size() - base, 1);
        checkOutput("single_addr", gotAddr[base], 0);
        checkOutput("single_data", gotData[base], 64'hE123_4000_0000_0000);

        // 16 incompressible beats -> 17 words, fail set
        $display("[TB] incompressible block");
        base = gotData.size();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 0, i == 15, 64'h1111_1111_1111_1111, w);
            if (i == 1 || i == 8 || i == 15) checkOutput($sformatf("ones_readyDrop%0d", i), w, 1);
        end
        waitDone("ones", 11'd1088, 1'b1);
        checkOutput("ones_words", gotData.size() - base, 17);
        for (int j = 0; j < 17; j++) begin
            checkOutput($sformatf("ones_addr%0d", j), gotAddr[base+j], j);
            checkOutput($sformatf("ones_data%0d", j), gotData[base+j], onesWord(j));
        end

        // Same block with a downstream stall in the middle
        $display("[TB] incompressible block with stall");
        base = gotData.size();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 0, i == 15, 64'h1111_1111_1111_1111, w);
            if (i == 5) ready_i = 1'b0;
            if (i == 6) begin
                @(negedge clk);
                heldData = data_o;
                heldAddr = addr_o;
                checkOutput("stall_valid", valid_o, 1);
                checkOutput("stall_addr", heldAddr, 5);
                checkOutput("stall_data", heldData, onesWord(5));
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall_validHeld%0d", c), valid_o, 1);
                    checkOutput($sformatf("stall_dataHeld%0d", c), data_o, heldData);
                    checkOutput($sformatf("stall_addrHeld%0d", c), addr_o, heldAddr);
                    checkOutput($sformatf("stall_readyLow%0d", c), ready_o, 0);
                end
                @(posedge clk);
                #1 ready_i = 1'b1;
            end
        end
        waitDone("stall", 11'd1088, 1'b1);
        checkOutput("stall_words", gotData.size() - base, 17);
        for (int j = 0; j < 17; j++) begin
            checkOutput($sformatf("stall_addr%0d", j), gotAddr[base+j], j);
            checkOutput($sformatf("stall_data%0d", j), gotData[base+j], onesWord(j));
        end

        // sop at beat 5 abandons the first block
        $display("[TB] abort by new sop");
        base      = gotData.size();
        doneBase  = doneCnt;
        abortBase = abortCnt;
        for (int i = 0; i < 4; i++) applyStimulus(i == 0, 1'b0, 64'h0000_0000_0000_1234, w);
        applyStimulus(1'b1, 1'b0, 64'h0, w);
        @(negedge clk);
        checkOutput("abort_pulse", abort_o, 1);
        applyStimulus(1'b0, 1'b1, 64'h0000_0000_0000_1234, w);
        waitDone("abort", 11'd24, 1'b0);
        checkOutput("abort_count", abortCnt - abortBase, 1);
        checkOutput("abort_doneCount", doneCnt - doneBase, 1);
        checkOutput("abort_words", gotData.size() - base, 2);
        checkOutput("abort_oldAddr", gotAddr[base], 0);
        checkOutput("abort_oldData", gotData[base], 64'hE123_4E12_34E1_234E);
        checkOutput("abort_newAddr", gotAddr[base+1], 0);
        checkOutput("abort_newData", gotData[base+1], 64'hFE12_3400_0000_0000);

        // Reset in FLUSH with a word pending
        $display("[TB] reset during flush");
        ready_i  = 1'b0;
        doneBase = doneCnt;
        applyStimulus(1'b1, 1'b1, 64'h1111_1111_1111_1111, w);
        @(negedge clk);
        @(negedge clk);
        checkOutput("flushRst_pending", valid_o, 1);
        checkOutput("flushRst_readyLow", ready_o, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("flushRst_valid", valid_o, 0);
        checkOutput("flushRst_done", done_o, 0);
        checkOutput("flushRst_ready", ready_o, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_i = 1'b1;
        base = gotData.size();
        applyStimulus(1'b1, 1'b1, 64'h0000_0000_0000_1234, w);
        waitDone("afterRst", 11'd20, 1'b0);
        checkOutput("afterRst_doneCount", doneCnt - doneBase, 1);
        checkOutput("afterRst_words", gotData.size() - base, 1);
        checkOutput("afterRst_addr", gotAddr[base], 0);
        checkOutput("afterRst_data", gotData[base], 64'hE123_4000_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aidc_lite_comp_zrle_param.md
Name: aidc_lite_comp_zrle_param

Overview:
- Parametrised zero-run/zero-symbol compressor, the next generation of the fixed 64-bit/16-bit-symbol ZRLE compressor.
- Splits each input beat into N = DATA_W/SYM_W symbols and emits an N-bit zero bitmap followed by the non-zero symbols.
- Packs the variable-length codes into OUT_W-bit words addressed within a block, with valid/ready backpressure on both sides.
- Reports total compressed size and fail (size > FAIL_BITS) at block end; sits between the block splitter and the compressed-block buffer.

Parameters:
- DATA_W, 64, input beat width; must be a multiple of SYM_W.
- SYM_W, 16, symbol width; N = DATA_W/SYM_W, N ≥ 2.
- OUT_W, 64, packed output word width; OUT_W ≥ SYM_W.
- BLK_BEATS, 16, maximum beats per block; used for counter sizing only.
- FAIL_BITS, 512, compressed-size threshold; fail when strictly greater.
- Derived: CODE_MAX = N+DATA_W; BITS_W = clog2(BLK_BEATS*CODE_MAX+1); ADDR_W = clog2(ceil(BLK_BEATS*CODE_MAX/OUT_W)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i&ready_o.
- sop_i  in  1  first beat of block.
- eop_i  in  1  last beat of block.
- data_i  in  DATA_W  input beat.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts word when valid_o&ready_i.
- addr_o  out  ADDR_W  word index within block, 0-based.
- data_o  out  OUT_W  packed code word, MSB-first.
- done_o  out  1  one-cycle block-end pulse.
- fail_o  out  1  valid with done_o: blk_bits_o > FAIL_BITS.
- blk_bits_o  out  BITS_W  valid with done_o: total code bits.
- abort_o  out  1  one-cycle pulse: block abandoned by a new sop.

Behaviour:
- Reset: all outputs 0 except ready_o, which is 1 (state IDLE); buffer fill, address and bit counters cleared. Reset mid-block drops the block and any pending word with no done_o.
- Code per beat:
  - bitmap bit k = (symbol k == 0); symbol k = data_i[k*SYM_W +: SYM_W]; bitmap MSB = symbol N-1.
  - Non-zero symbols follow the bitmap, highest index first.
  - size = N + SYM_W*(number of non-zero symbols).
- Packing:
  - Buffer holds fill f bits, left-aligned; width OUT_W-1+CODE_MAX.
  - An accepted beat appends its code at bit offset f; f += size; blk_bits += size.
  - ready_o = (state==IDLE or RUN) && f < OUT_W.
- Output register:
  - When f ≥ OUT_W and the output register is empty or is being consumed this cycle, the top OUT_W bits move to data_o, valid_o=1, addr_o=word count, word count+1, f -= OUT_W.
  - Sustains one word per cycle.
  - valid_o, data_o and addr_o are held stable while ready_i=0.
- Latency: the first word appears 1 cycle after the accepting edge that makes f ≥ OUT_W.
- States:
  - IDLE: beats without sop are accepted and dropped. An accepted beat with sop starts the block and goes to RUN, or to FLUSH if eop is also set.
  - RUN: accepted eop → FLUSH. Accepted sop → abort_o pulse; f, word count and blk_bits are cleared and the beat starts the new block. An already-loaded output word is still delivered.
  - FLUSH (ready_o=0): drain full words. If 0 < f < OUT_W, emit a final word with the remainder left-aligned and zero-padded LSBs. When the last word handshakes (or immediately if none remain) → DONE.
  - DONE: done_o=1, fail_o and blk_bits_o valid for one cycle → IDLE.
- Width rules: counters never wrap within BLK_BEATS beats. Beats beyond BLK_BEATS have undefined result; no check is made.

Test Plan:
- 16 all-zero beats, ready_i=1 → one word 0xFFFF_FFFF_FFFF_FFFF at addr 0; done_o with blk_bits_o=64, fail_o=0.
- Single beat, sop=eop=1, data 0x0000_0000_0000_1234 → one word 0xE123_4000_0000_0000 at addr 0; blk_bits_o=20, fail_o=0.
- 16 beats of 0x1111_1111_1111_1111 → 17 words at addr 0..16; ready_o drops for one cycle whenever f ≥ 64; blk_bits_o=1088, fail_o=1.
- Repeat the previous case with ready_i=0 for 10 cycles mid-block → valid_o/data_o/addr_o stable, ready_o=0, final word stream identical to the no-stall case.
- sop at beat 5 of a block → abort_o pulse, no done_o for the first block; second block words start at addr 0 and its blk_bits_o excludes the first block.
- rst asserted in FLUSH with a word pending → valid_o=0, done_o=0, ready_o=1 without waiting for a clock edge; the next block behaves as from power-up.
